// File: rtl/mem_arb_pkg.sv
// Shared constants and encodings for the I/D memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way request picker: round-robin against the previous grant, or D-first when fixed.
module arb_rr2
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_I;
    if (req[REQ_I] && req[REQ_D]) begin
      grant_id = FIXED_PRIO ? REQ_D : ~last_grant;
    end else if (req[REQ_D]) begin
      grant_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache, one transaction at a time.
// State table: S_IDLE = nothing outstanding | S_GRANT_I = I owns memory | S_GRANT_D = D owns memory.
module mem_arbiter #(
  parameter int ADDR_W     = mem_arb_pkg::ADDR_W,
  parameter int LINE_W     = mem_arb_pkg::LINE_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              ic_mem_read,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  output logic [LINE_W-1:0] ic_mem_rdata,
  output logic              ic_mem_ready,
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [LINE_W-1:0] dc_mem_wdata,
  output logic [LINE_W-1:0] dc_mem_rdata,
  output logic              dc_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  import mem_arb_pkg::arb_state_e;
  import mem_arb_pkg::S_IDLE;
  import mem_arb_pkg::S_GRANT_I;
  import mem_arb_pkg::S_GRANT_D;
  import mem_arb_pkg::REQ_I;
  import mem_arb_pkg::REQ_D;

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0] req;
  logic       grant_valid;
  logic       grant_id;

  assign req[REQ_I] = ic_mem_read;
  assign req[REQ_D] = dc_mem_read | dc_mem_write;

  arb_rr2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_pick (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant_id;
          if (grant_id == REQ_I) begin
            state_d     = S_GRANT_I;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = ic_mem_addr;
          end else begin
            // A simultaneous read+write from the D-cache is treated as a writeback.
            state_d     = S_GRANT_D;
            mem_read_d  = ~dc_mem_write;
            mem_write_d = dc_mem_write;
            mem_addr_d  = dc_mem_addr;
            mem_wdata_d = dc_mem_wdata;
          end
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        if (mem_ready) begin
          state_d     = S_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= REQ_D;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign ic_mem_ready = mem_ready & (state_q == S_GRANT_I);
  assign dc_mem_ready = mem_ready & (state_q == S_GRANT_D);
  assign ic_mem_rdata = mem_rdata;
  assign dc_mem_rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one 128-bit line-wide memory port between the instruction cache (read-only) and the data cache (read/write, write-back).
- Sits between the two cache mem_* interfaces and the memory model/controller.
- Each cache keeps its existing level handshake and sees a private memory port.
- Arbitration is per transaction (round-robin or fixed priority); memory-side command outputs are registered.

Parameters:
- ADDR_W, 28, line address width (word address minus 2 offset bits)
- LINE_W, 128, line data width
- FIXED_PRIO, 0, 0 = round-robin between I and D; 1 = D always wins ties

Ports:
- clk  in  1  system clock
- proc_reset  in  1  reset, asynchronous, active-high
- ic_mem_read  in  1  I-cache line read request (level, held until ic_mem_ready)
- ic_mem_addr  in  ADDR_W  I-cache line address
- ic_mem_rdata  out  LINE_W  line data to I-cache
- ic_mem_ready  out  1  I-cache transaction done (1-cycle pulse)
- dc_mem_read  in  1  D-cache line read request
- dc_mem_write  in  1  D-cache line write request (writeback)
- dc_mem_addr  in  ADDR_W  D-cache line address
- dc_mem_wdata  in  LINE_W  D-cache writeback data
- dc_mem_rdata  out  LINE_W  line data to D-cache
- dc_mem_ready  out  1  D-cache transaction done (1-cycle pulse)
- mem_read  out  1  memory read command (registered)
- mem_write  out  1  memory write command (registered)
- mem_addr  out  ADDR_W  memory line address (registered)
- mem_wdata  out  LINE_W  memory write data (registered)
- mem_rdata  in  LINE_W  memory read data
- mem_ready  in  1  memory done (1-cycle pulse)

Behaviour:
- Reset:
  - state = S_IDLE; mem_read, mem_write, mem_addr, mem_wdata = 0.
  - last_grant = D, so the first tie goes to I.
  - Reset mid-transaction abandons it silently.
- States:
  - S_IDLE: no transaction outstanding.
  - S_GRANT_I: I-cache owns memory.
  - S_GRANT_D: D-cache owns memory.
- S_IDLE arbitration, on requests sampled in cycle t:
  - Only I requests (ic_mem_read): go to S_GRANT_I.
  - Only D requests (dc_mem_read | dc_mem_write): go to S_GRANT_D.
  - Both request:
    - FIXED_PRIO=1: grant D.
    - FIXED_PRIO=0: grant the requester that is not last_grant.
  - On grant:
    - Latch addr, wdata and command into the mem_* registers; they are visible at cycle t+1.
    - Update last_grant.
  - Arbitration latency is 1 cycle; a lone request in IDLE at cycle t drives mem_* at t+1.
- S_GRANT_x:
  - mem_* are held stable, independent of requester inputs, until mem_ready.
  - On mem_ready in cycle t:
    - x_mem_ready = 1 combinationally in cycle t.
    - mem_read/mem_write are cleared at edge t+1; next state is S_IDLE.
- Grant is never made directly from S_GRANT_x. The minimum gap between transactions is 1 IDLE cycle, which guarantees a requester's dropped request is observed first.
- Ready routing:
  - x_mem_ready = mem_ready & (state==S_GRANT_x).
  - The non-granted ready is always 0.
  - mem_ready in S_IDLE is ignored.
- Data routing: ic_mem_rdata = dc_mem_rdata = mem_rdata (broadcast); only the ready qualifies it.
- dc_mem_read and dc_mem_write both high: write wins (mem_write=1, mem_read=0); illegal per cache contract.
- Requester drops its request while granted: the transaction still completes and the ready pulse is still delivered to that requester.
- A request newly raised while the other side is granted waits, held by the requester, and is granted from the next IDLE cycle.
- Round-robin guarantee: with both requesting continuously, grants alternate I, D, I, D; no starvation.

Decomposition:
- Package mem_arb_pkg:
  - ADDR_W and LINE_W constants.
  - State encoding S_IDLE=2'd0, S_GRANT_I=2'd1, S_GRANT_D=2'd2.
  - Requester ID encoding (REQ_I=0, REQ_D=1).
- Sub-module arb_rr2 (optional):
  - Combinational 2-way round-robin/fixed picker; inputs req[1:0], last_grant, FIXED_PRIO; output grant id.
  - The top keeps the FSM and registers.

Test Plan:
- Reset during S_GRANT_D with mem_write=1 -> all mem_* = 0 immediately, state IDLE. A fresh ic_mem_read to addr 0x0000010 then gets mem_read=1 one cycle after release.
- Lone I read, addr 0x0ABCDEF, memory ready after 5 cycles with rdata 0x...DEADBEEF:
  - mem_read=1 and mem_addr=0x0ABCDEF one cycle after the request.
  - ic_mem_ready pulses in the ready cycle; dc_mem_ready stays 0.
- Simultaneous I read 0x10 and D write 0x20 after reset, FIXED_PRIO=0 -> I served first, then one IDLE cycle, then mem_write=1 with mem_addr=0x20 and mem_wdata=dc_mem_wdata.
- Both requesting continuously for 6 transactions, FIXED_PRIO=0 -> grant order I,D,I,D,I,D. With FIXED_PRIO=1 -> D until dc requests stop.
- D writeback 0x40 then D read 0x80 back-to-back while I waits (FIXED_PRIO=0):
  - After the write completes, I is granted before the D read.
  - mem_addr never changes mid-transaction.
- Requester changes dc_mem_addr while granted -> mem_addr holds the latched value until mem_ready; a stray mem_ready in IDLE produces no cache ready pulse.
